// File: rtl/branch_redirect_ctrl.sv
// Branch recovery sequencer: tracks in-flight predictions from IF to ID, issues a
// registered redirect/flush on a mispredict, holds fetch, and trains the predictor.
module branch_redirect_ctrl #(
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter int CNT_W     = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              pred_valid,
    input  logic              pred_taken,
    input  logic [31:0]       pred_alt_pc,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              pred_ready,
    output logic              pc_redirect_valid,
    output logic [31:0]       pc_redirect,
    output logic              flush_if,
    output logic              flush_id,
    output logic              hold_if,
    output logic              upd_valid,
    output logic              upd_taken,
    output logic [PTR_W:0]    inflight,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              err_underflow
);

    localparam int             FC_W    = $clog2(FLUSH_CYC) + 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [FC_W-1:0] FLUSH_C = FC_W'(FLUSH_CYC);

    typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r, state_nxt_s;
    logic [FC_W-1:0]    fcnt_r, fcnt_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [PTR_W:0]     count_r, count_nxt_s;
    logic [31:0]        alt_mem_r [DEPTH];
    logic               taken_mem_r [DEPTH];

    logic               pred_ready_r, redirect_valid_r, flush_if_r, flush_id_r, hold_if_r;
    logic               upd_valid_r, upd_taken_r, err_r;
    logic [31:0]        pc_redirect_r;
    logic [CNT_W-1:0]   hit_r, miss_r;

    logic               empty_s, push_s, pop_s, underflow_s, mispredict_s;

    assign empty_s      = (count_r == {(PTR_W+1){1'b0}});
    assign push_s       = pred_valid & pred_ready_r & ~stall;
    assign pop_s        = res_valid & ~stall & ~empty_s & (state_r == IDLE);
    assign underflow_s  = res_valid & ~stall & empty_s & (state_r == IDLE);
    assign mispredict_s = pop_s & (res_taken != taken_mem_r[rd_ptr_r]);

    // Recovery FSM next state: load the hold window on a mispredict, count down when not stalled.
    always_comb begin
        state_nxt_s = state_r;
        fcnt_nxt_s  = fcnt_r;
        case (state_r)
            IDLE: begin
                if (mispredict_s) begin
                    state_nxt_s = REDIRECT;
                    fcnt_nxt_s  = FLUSH_C;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REDIRECT: begin
                if (stall) begin
                    fcnt_nxt_s = fcnt_r;
                end else if (fcnt_r <= FC_W'(1)) begin
                    state_nxt_s = IDLE;
                    fcnt_nxt_s  = '0;
                end else begin
                    fcnt_nxt_s = fcnt_r - FC_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                fcnt_nxt_s  = '0;
            end
        endcase
    end

    // FIFO pointer/occupancy next state; a mispredict wipes every younger (wrong-path) entry.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (mispredict_s) begin
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
            count_nxt_s  = '0;
        end else begin
            if (push_s) wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            else        wr_ptr_nxt_s = wr_ptr_r;
            if (pop_s)  rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            else        rd_ptr_nxt_s = rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
                2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // State, FIFO storage and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            fcnt_r           <= '0;
            wr_ptr_r         <= '0;
            rd_ptr_r         <= '0;
            count_r          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                alt_mem_r[i]   <= 32'h0;
                taken_mem_r[i] <= 1'b0;
            end
            pred_ready_r     <= 1'b1;
            redirect_valid_r <= 1'b0;
            pc_redirect_r    <= 32'h0;
            flush_if_r       <= 1'b0;
            flush_id_r       <= 1'b0;
            hold_if_r        <= 1'b0;
            upd_valid_r      <= 1'b0;
            upd_taken_r      <= 1'b0;
            hit_r            <= '0;
            miss_r           <= '0;
            err_r            <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            fcnt_r   <= fcnt_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            if (push_s && !mispredict_s) begin
                alt_mem_r[wr_ptr_r]   <= pred_alt_pc;
                taken_mem_r[wr_ptr_r] <= pred_taken;
            end
            pred_ready_r     <= (count_nxt_s != DEPTH_C) && (state_nxt_s == IDLE);
            hold_if_r        <= (state_nxt_s == REDIRECT);
            redirect_valid_r <= mispredict_s;
            flush_if_r       <= mispredict_s;
            flush_id_r       <= mispredict_s;
            if (mispredict_s) pc_redirect_r <= alt_mem_r[rd_ptr_r];
            else              pc_redirect_r <= pc_redirect_r;
            upd_valid_r      <= pop_s;
            if (pop_s) upd_taken_r <= res_taken;
            else       upd_taken_r <= upd_taken_r;
            if (pop_s && !mispredict_s) hit_r <= sat_inc(hit_r);
            else                        hit_r <= hit_r;
            if (mispredict_s) miss_r <= sat_inc(miss_r);
            else              miss_r <= miss_r;
            err_r            <= err_r | underflow_s;
        end
    end

    assign pred_ready        = pred_ready_r;
    assign pc_redirect_valid = redirect_valid_r;
    assign pc_redirect       = pc_redirect_r;
    assign flush_if          = flush_if_r;
    assign flush_id          = flush_id_r;
    assign hold_if           = hold_if_r;
    assign upd_valid         = upd_valid_r;
    assign upd_taken         = upd_taken_r;
    assign inflight          = count_r;
    assign hit_cnt           = hit_r;
    assign miss_cnt          = miss_r;
    assign err_underflow     = err_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed, table-driven bench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, pred_valid, pred_taken, res_valid, res_taken;
    logic [31:0] pred_alt_pc;
    logic        pred_ready, pc_redirect_valid, flush_if, flush_id, hold_if;
    logic        upd_valid, upd_taken, err_underflow;
    logic [31:0] pc_redirect;
    logic [2:0]  inflight;
    logic [15:0] hit_cnt, miss_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        rdy;
        logic [2:0]  infl;
        logic        rv;
        logic [31:0] rpc;
        logic        fi;
        logic        fd;
        logic        hold;
        logic        uv;
        logic        ut;
        logic [15:0] hit;
        logic [15:0] miss;
        logic        err;
    } out_t;

    typedef struct {
        logic        pv;
        logic        pt;
        logic [31:0] alt;
        logic        rv;
        logic        rt;
        logic        st;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];

    branch_redirect_ctrl #(.DEPTH(4), .PTR_W(2), .CNT_W(16), .FLUSH_CYC(2)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_alt_pc(pred_alt_pc),
        .res_valid(res_valid), .res_taken(res_taken),
        .pred_ready(pred_ready), .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
        .flush_if(flush_if), .flush_id(flush_id), .hold_if(hold_if),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .inflight(inflight),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic out_t actual();
        out_t a;
        a = '{pred_ready, inflight, pc_redirect_valid, pc_redirect, flush_if, flush_id,
              hold_if, upd_valid, upd_taken, hit_cnt, miss_cnt, err_underflow};
        return a;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t a;
        a = actual();
        tests++;
        if (a !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, a, exp);
        end
    endtask

    task automatic add(input logic pv, input logic pt, input logic [31:0] alt,
                       input logic rv, input logic rt, input logic st,
                       input logic rdy, input logic [2:0] infl, input logic rvld,
                       input logic [31:0] rpc, input logic fl, input logic hold,
                       input logic uv, input logic ut, input logic [15:0] hit,
                       input logic [15:0] miss, input logic err);
        vec_t v;
        v.pv = pv; v.pt = pt; v.alt = alt; v.rv = rv; v.rt = rt; v.st = st;
        v.exp = '{rdy, infl, rvld, rpc, fl, fl, hold, uv, ut, hit, miss, err};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic pv, input logic pt, input logic [31:0] alt,
                         input logic rv, input logic rt, input logic st);
        pred_valid = pv; pred_taken = pt; pred_alt_pc = alt;
        res_valid = rv; res_taken = rt; stall = st;
    endtask

    initial begin
        // pv pt alt rv rt st | rdy infl rv rpc fl hold uv ut hit miss err
        // Fill to 4, drop a 5th, resolve all four correctly.
        add(1,1,32'h100, 0,0,0, 1,3'd1,0,32'h0,0,0,0,0,16'd0,16'd0,0);
        add(1,1,32'h104, 0,0,0, 1,3'd2,0,32'h0,0,0,0,0,16'd0,16'd0,0);
        add(1,1,32'h108, 0,0,0, 1,3'd3,0,32'h0,0,0,0,0,16'd0,16'd0,0);
        add(1,1,32'h10C, 0,0,0, 0,3'd4,0,32'h0,0,0,0,0,16'd0,16'd0,0);
        add(1,1,32'h110, 0,0,0, 0,3'd4,0,32'h0,0,0,0,0,16'd0,16'd0,0);
        add(0,0,32'h0,   1,1,0, 1,3'd3,0,32'h0,0,0,1,1,16'd1,16'd0,0);
        add(0,0,32'h0,   1,1,0, 1,3'd2,0,32'h0,0,0,1,1,16'd2,16'd0,0);
        add(0,0,32'h0,   1,1,0, 1,3'd1,0,32'h0,0,0,1,1,16'd3,16'd0,0);
        add(0,0,32'h0,   1,1,0, 1,3'd0,0,32'h0,0,0,1,1,16'd4,16'd0,0);
        add(0,0,32'h0,   0,0,0, 1,3'd0,0,32'h0,0,0,0,1,16'd4,16'd0,0);
        // Mispredict on first of three; res_valid during REDIRECT is ignored.
        add(1,1,32'h200, 0,0,0, 1,3'd1,0,32'h0,  0,0,0,1,16'd4,16'd0,0);
        add(1,1,32'h300, 0,0,0, 1,3'd2,0,32'h0,  0,0,0,1,16'd4,16'd0,0);
        add(1,1,32'h400, 0,0,0, 1,3'd3,0,32'h0,  0,0,0,1,16'd4,16'd0,0);
        add(0,0,32'h0,   1,0,0, 0,3'd0,1,32'h200,1,1,1,0,16'd4,16'd1,0);
        add(0,0,32'h0,   1,1,0, 0,3'd0,0,32'h200,0,1,0,0,16'd4,16'd1,0);
        add(0,0,32'h0,   0,0,0, 1,3'd0,0,32'h200,0,0,0,0,16'd4,16'd1,0);
        // Mispredict with a push in the same cycle: push discarded.
        add(1,0,32'h500, 0,0,0, 1,3'd1,0,32'h200,0,0,0,0,16'd4,16'd1,0);
        add(1,1,32'h600, 1,1,0, 0,3'd0,1,32'h500,1,1,1,1,16'd4,16'd2,0);
        add(0,0,32'h0,   0,0,0, 0,3'd0,0,32'h500,0,1,0,1,16'd4,16'd2,0);
        add(0,0,32'h0,   0,0,0, 1,3'd0,0,32'h500,0,0,0,1,16'd4,16'd2,0);
        // Stall three cycles inside REDIRECT: hold stretches, strobes pulse once.
        add(1,1,32'h700, 0,0,0, 1,3'd1,0,32'h500,0,0,0,1,16'd4,16'd2,0);
        add(0,0,32'h0,   1,0,0, 0,3'd0,1,32'h700,1,1,1,0,16'd4,16'd3,0);
        add(0,0,32'h0,   0,0,1, 0,3'd0,0,32'h700,0,1,0,0,16'd4,16'd3,0);
        add(0,0,32'h0,   0,0,1, 0,3'd0,0,32'h700,0,1,0,0,16'd4,16'd3,0);
        add(0,0,32'h0,   0,0,1, 0,3'd0,0,32'h700,0,1,0,0,16'd4,16'd3,0);
        add(0,0,32'h0,   0,0,0, 0,3'd0,0,32'h700,0,1,0,0,16'd4,16'd3,0);
        add(0,0,32'h0,   0,0,0, 1,3'd0,0,32'h700,0,0,0,0,16'd4,16'd3,0);
        // Stalled push in IDLE is not taken.
        add(1,1,32'h800, 0,0,1, 1,3'd0,0,32'h700,0,0,0,0,16'd4,16'd3,0);
        // Underflow: sticky error, no update, counters unchanged.
        add(0,0,32'h0,   1,1,0, 1,3'd0,0,32'h700,0,0,0,0,16'd4,16'd3,1);
        add(0,0,32'h0,   0,0,0, 1,3'd0,0,32'h700,0,0,0,0,16'd4,16'd3,1);

        drive(0,0,32'h0,0,0,0);
        rst = 1'b1;
        #12;
        check("reset_held", '{1'b1,3'd0,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,16'd0,1'b0});
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_released", '{1'b1,3'd0,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,16'd0,1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].pv, vecs[i].pt, vecs[i].alt, vecs[i].rv, vecs[i].rt, vecs[i].st);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Mid-redirect asynchronous reset aborts recovery and clears everything immediately.
        drive(1,1,32'h900,0,0,0);
        @(posedge clk); #1;
        drive(0,0,32'h0,1,0,0);
        @(posedge clk); #1;
        check("pre_abort_redirect", '{1'b0,3'd0,1'b1,32'h900,1'b1,1'b1,1'b1,1'b1,1'b0,16'd4,16'd4,1'b1});
        drive(0,0,32'h0,0,0,0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_abort", '{1'b1,3'd0,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,16'd0,1'b0});
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("after_abort_idle", '{1'b1,3'd0,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,16'd0,1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences pipeline recovery around the 2-bit branch predictor.
- Tracks in-flight predicted branches in a small FIFO, from IF prediction to ID resolution.
- On a mispredict, issues a registered PC redirect, flushes IF/ID, holds fetch for a programmable window, and discards wrong-path predictions.
- Drives predictor training updates and hit/miss statistics.

Parameters:
DEPTH, 4, maximum in-flight predicted branches (power of 2, >=2)
PTR_W, 2, log2(DEPTH)
CNT_W, 16, width of hit/miss statistic counters
FLUSH_CYC, 2, cycles fetch is held after a redirect (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
stall  in  1  pipeline stall; freezes FIFO, FSM and all outputs except statistics hold
pred_valid  in  1  IF issues a predicted branch this cycle
pred_taken  in  1  predictor direction for that branch
pred_alt_pc  in  32  PC of the path NOT chosen (recovery target)
res_valid  in  1  ID resolves the oldest in-flight branch
res_taken  in  1  actual direction
pred_ready  out  1  FIFO can accept a prediction
pc_redirect_valid  out  1  one-cycle redirect strobe
pc_redirect  out  32  recovery PC, valid with strobe
flush_if  out  1  squash IF stage
flush_id  out  1  squash ID stage
hold_if  out  1  block fetch during recovery
upd_valid  out  1  predictor training strobe
upd_taken  out  1  actual direction for training
inflight  out  PTR_W+1  current FIFO occupancy
hit_cnt  out  CNT_W  correct predictions, saturating
miss_cnt  out  CNT_W  mispredictions, saturating
err_underflow  out  1  sticky: res_valid seen with FIFO empty

Behaviour:
- Reset (async, immediate): FIFO empty, pointers 0, FSM=IDLE, all outputs 0 except pred_ready=1; counters and err_underflow cleared. Reset mid-redirect aborts recovery.
- FIFO entry = {pred_taken, pred_alt_pc}.
- Push when pred_valid & pred_ready & ~stall. pred_ready = ~full & (state==IDLE).
- pred_valid while ~pred_ready is dropped; no error is flagged.
- Pop head when res_valid & ~stall & ~empty.
- res_valid & ~stall & empty: no pop, no update; set err_underflow (sticky until rst).
- Simultaneous push and pop (correct prediction): both occur; occupancy unchanged. This is legal when full, since pred_ready is already 0.
- Pointer wrap: modulo DEPTH. inflight is 0..DEPTH.
- On every pop at cycle T, the following appear at T+1 (registered): upd_valid=1 for one cycle and upd_taken=res_taken.
- Correct prediction (res_taken==head.pred_taken): hit_cnt+1 at T+1, saturating at all-ones.
- Mispredict (res_taken!=head.pred_taken) at cycle T:
  - T+1: pc_redirect_valid=1, pc_redirect=head.pred_alt_pc, flush_if=1, flush_id=1, each for one cycle.
  - T+1: miss_cnt+1 (saturating); FIFO cleared (inflight=0), since all younger entries are wrong-path.
  - Any push in cycle T is discarded.
  - FSM IDLE->REDIRECT. hold_if=1 and pred_ready=0 for FLUSH_CYC cycles (T+1..T+FLUSH_CYC). Returns to IDLE at T+FLUSH_CYC+1.
- During REDIRECT, res_valid is ignored: no pop, no error.
- FSM states: IDLE, REDIRECT (down-counter of width clog2(FLUSH_CYC)+1).
- stall=1:
  - No push, no pop, REDIRECT counter frozen.
  - Strobes (pc_redirect_valid, flush_*, upd_valid) still deassert after their single cycle and are never repeated.
  - hold_if stays asserted while frozen in REDIRECT.
- pc_redirect holds its last value when the strobe is low.

Test Plan:
- Reset then idle: assert rst mid-cycle -> all outputs 0 immediately, pred_ready=1, inflight=0; rst released -> unchanged.
- Push 4 predictions (taken, alt 0x100/0x104/0x108/0x10C) -> inflight=4, pred_ready=0; 5th pred_valid dropped. Resolve all 4 taken -> hit_cnt=4, four upd_valid pulses with upd_taken=1, inflight=0.
- Push 3 entries (alt 0x200,0x300,0x400), resolve first not-taken vs predicted taken -> next cycle pc_redirect_valid=1, pc_redirect=0x200, flush_if=flush_id=1, inflight=0, miss_cnt=1; hold_if=1 for exactly 2 cycles; pred_ready=1 on the 3rd.
- Mispredict with pred_valid asserted same cycle -> pushed entry discarded, inflight=0 after redirect.
- stall=1 for 3 cycles in REDIRECT -> hold_if stays 1 for 2+3 cycles total; flush strobes pulse only once.
- res_valid with empty FIFO -> err_underflow=1 and stays set; no upd_valid; counters unchanged.
